// File: rtl/pe_crossover_stage.sv
// NEAT PE crossover stage: builds one child gene per non-bubble parent pair with LFSR-driven
// uniform crossover, buffers children two deep. Optional weight mutation: PE_CROSSOVER_MUTATE_EN.
module pe_crossover_stage #(
   parameter int         GENE_SZ  = 64,
   parameter int         ATTR_SZ  = 8,
   parameter int         CNT_SZ   = 10,
   parameter logic [7:0] MUT_RATE = 8'd16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               seed_load,
   input  logic [15:0]        seed,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               bubble,
   input  logic               bias,
   input  logic [GENE_SZ-1:0] gene1_in,
   input  logic [GENE_SZ-1:0] gene2_in,
   input  logic               genome_last,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [GENE_SZ-1:0] child_gene,
   output logic [CNT_SZ-1:0]  gene_count,
   output logic               genome_done
);

   localparam int NATTR = GENE_SZ / ATTR_SZ;

   typedef enum logic [1:0] {
      SEED  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t             state;
   logic [15:0]        lfsr;
   logic [15:0]        lfsr_next;
   logic [GENE_SZ-1:0] mem [2];
   logic               wr_ptr;
   logic               rd_ptr;
   logic [1:0]         occ;
   logic               accept;
   logic               push;
   logic               pop;
   logic               advance;
   logic [GENE_SZ-1:0] cross_gene;
   logic [GENE_SZ-1:0] mixed_gene;
   logic [GENE_SZ-1:0] child_new;

   // Handshakes on both sides: a transfer happens on any rising edge where valid and ready are both high.
   assign in_ready   = (state == RUN) && (occ != 2'd2);
   assign accept     = in_valid && in_ready;
   assign push       = accept && !bubble;
   assign advance    = push && !bias;
   assign out_valid  = (occ != 2'd0);
   assign pop        = out_valid && out_ready;
   assign child_gene = out_valid ? mem[rd_ptr] : '0;
   assign lfsr_next  = (lfsr >> 1) ^ (lfsr[0] ? 16'hB400 : 16'h0000);

   for (genvar g = 0; g < NATTR; g++) begin : g_attr
      assign cross_gene[g*ATTR_SZ +: ATTR_SZ] = lfsr[g % 16] ? gene2_in[g*ATTR_SZ +: ATTR_SZ]
                                                              : gene1_in[g*ATTR_SZ +: ATTR_SZ];
   end

`ifdef PE_CROSSOVER_MUTATE_EN
   logic [ATTR_SZ:0]   mut_sum;
   logic [ATTR_SZ-1:0] mut_weight;

   // Sign-extend weight and the 3-bit delta one bit wider so overflow shows as a sign disagreement.
   assign mut_sum = {cross_gene[ATTR_SZ-1], cross_gene[ATTR_SZ-1:0]}
                  + {{(ATTR_SZ-2){lfsr_next[2]}}, lfsr_next[2:0]};

   always_comb begin
      mut_weight = mut_sum[ATTR_SZ-1:0];
      if (mut_sum[ATTR_SZ] != mut_sum[ATTR_SZ-1])
         mut_weight = mut_sum[ATTR_SZ] ? {1'b1, {(ATTR_SZ-1){1'b0}}} : {1'b0, {(ATTR_SZ-1){1'b1}}};
   end

   always_comb begin
      mixed_gene = cross_gene;
      if (lfsr_next[15:8] < MUT_RATE)
         mixed_gene[ATTR_SZ-1:0] = mut_weight;
   end
`else
   assign mixed_gene = cross_gene;

   // Mutation is compiled out in this build, so the threshold has no effect.
   if (MUT_RATE == 8'd0) begin : g_mut_rate_unused
   end
`endif

   assign child_new = bias ? gene1_in : mixed_gene;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= SEED;
         lfsr        <= 16'h0001;
         mem[0]      <= '0;
         mem[1]      <= '0;
         wr_ptr      <= 1'b0;
         rd_ptr      <= 1'b0;
         occ         <= 2'd0;
         gene_count  <= '0;
         genome_done <= 1'b0;
      end else begin
         if (seed_load)
            lfsr <= (seed == 16'h0000) ? 16'h0001 : seed;
         else if (advance)
            lfsr <= lfsr_next;

         if (push) begin
            mem[wr_ptr] <= child_new;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop)
            rd_ptr <= ~rd_ptr;
         occ <= occ + {1'b0, push} - {1'b0, pop};

         if (push && (gene_count != {CNT_SZ{1'b1}}))
            gene_count <= gene_count + 1'b1;

         genome_done <= 1'b0;
         case (state)
            SEED: begin
               if (seed_load)
                  state <= RUN;
            end
            RUN: begin
               if (accept && genome_last)
                  state <= DRAIN;
            end
            DRAIN: begin
               // The done pulse is shown for one cycle with the final count, then the count clears.
               if (genome_done) begin
                  gene_count <= '0;
                  state      <= RUN;
               end else if (occ == 2'd0) begin
                  genome_done <= 1'b1;
               end
            end
            default: state <= SEED;
         endcase
      end
   end

endmodule

// File: tb/tb_pe_crossover_stage.sv
// Bench for pe_crossover_stage: directed steps plus random pairs checked against a behavioural model.
module tb_pe_crossover_stage;

   localparam int         GENE_SZ  = 64;
   localparam int         ATTR_SZ  = 8;
   localparam int         CNT_SZ   = 10;
   localparam int         NATTR    = GENE_SZ / ATTR_SZ;
   localparam logic [7:0] MUT_RATE = 8'hFF;

   logic               clk = 1'b0;
   logic               rst;
   logic               seed_load;
   logic [15:0]        seed;
   logic               in_valid;
   logic               in_ready;
   logic               bubble;
   logic               bias;
   logic [GENE_SZ-1:0] gene1_in;
   logic [GENE_SZ-1:0] gene2_in;
   logic               genome_last;
   logic               out_valid;
   logic               out_ready;
   logic [GENE_SZ-1:0] child_gene;
   logic [CNT_SZ-1:0]  gene_count;
   logic               genome_done;

   int                 n_asserts = 0;
   int                 n_fails   = 0;
   logic [15:0]        m_lfsr;
   int                 m_count;
   logic [GENE_SZ-1:0] exp_q[$];
   logic               rand_done;

   pe_crossover_stage #(
      .GENE_SZ (GENE_SZ),
      .ATTR_SZ (ATTR_SZ),
      .CNT_SZ  (CNT_SZ),
      .MUT_RATE(MUT_RATE)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .seed_load  (seed_load),
      .seed       (seed),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .bubble     (bubble),
      .bias       (bias),
      .gene1_in   (gene1_in),
      .gene2_in   (gene2_in),
      .genome_last(genome_last),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .child_gene (child_gene),
      .gene_count (gene_count),
      .genome_done(genome_done)
   );

   // Clock / reset
   always #5 clk = ~clk;

   initial begin
      #500000;
      n_fails++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference model
   function automatic logic [15:0] lfsr_step(input logic [15:0] l);
      return (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
   endfunction

   function automatic logic [63:0] model_child(input logic [63:0] g1, input logic [63:0] g2,
                                               input logic [15:0] l);
      logic [63:0] c;
      logic [15:0] nl;
      int          w;
      c  = '0;
      nl = lfsr_step(l);
      for (int i = 0; i < NATTR; i++) begin
         if (l[i % 16]) c[i*ATTR_SZ +: ATTR_SZ] = g2[i*ATTR_SZ +: ATTR_SZ];
         else           c[i*ATTR_SZ +: ATTR_SZ] = g1[i*ATTR_SZ +: ATTR_SZ];
      end
`ifdef PE_CROSSOVER_MUTATE_EN
      if (nl[15:8] < MUT_RATE) begin
         w = int'($signed(c[7:0])) + int'($signed(nl[2:0]));
         if (w > 127)  w = 127;
         if (w < -128) w = -128;
         c[7:0] = w[7:0];
      end
`endif
      return c;
   endfunction

   task automatic model_accept(input logic b, input logic bi, input logic [63:0] g1,
                               input logic [63:0] g2);
      if (!b) begin
         if (bi) begin
            exp_q.push_back(g1);
         end else begin
            exp_q.push_back(model_child(g1, g2, m_lfsr));
            m_lfsr = lfsr_step(m_lfsr);
         end
         if (m_count < 1023) m_count++;
      end
   endtask

   // Scoreboard: every popped child must match the head of the expected queue.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) check("unexpected_child", {63'b0, out_valid}, 64'd0);
         else                   check("child_order", child_gene, exp_q.pop_front());
      end
   end

   // Driver tasks: all called and returning at posedge + 1.
   task automatic load_seed(input logic [15:0] s);
      seed      = s;
      seed_load = 1'b1;
      @(posedge clk); #1;
      seed_load = 1'b0;
      m_lfsr    = (s == 16'h0000) ? 16'h0001 : s;
   endtask

   task automatic send_pair(input logic b, input logic bi, input logic [63:0] g1,
                            input logic [63:0] g2, input logic last);
      int n;
      n           = 0;
      in_valid    = 1'b1;
      bubble      = b;
      bias        = bi;
      gene1_in    = g1;
      gene2_in    = g2;
      genome_last = last;
      @(negedge clk);
      while (!in_ready && n < 200) begin
         n++;
         @(negedge clk);
      end
      check("accept_timeout", {63'b0, in_ready}, 64'd1);
      if (in_ready) model_accept(b, bi, g1, g2);
      @(posedge clk); #1;
      in_valid    = 1'b0;
      genome_last = 1'b0;
   endtask

   task automatic wait_done(input int exp_cnt);
      int n;
      n = 0;
      @(negedge clk);
      while (!genome_done && n < 200) begin
         n++;
         @(negedge clk);
      end
      check("done_pulse", {63'b0, genome_done}, 64'd1);
      check("done_count", {54'b0, gene_count}, exp_cnt);
      @(negedge clk);
      check("done_single", {63'b0, genome_done}, 64'd0);
      check("count_cleared", {54'b0, gene_count}, 64'd0);
      check("ready_after_done", {63'b0, in_ready}, 64'd1);
      m_count = 0;
      @(posedge clk); #1;
   endtask

   initial begin
      logic [15:0] s6;
      logic [15:0] tmp;
      logic [63:0] g1;
      logic [63:0] g2;

      rst         = 1'b1;
      seed_load   = 1'b0;
      seed        = 16'h0;
      in_valid    = 1'b0;
      bubble      = 1'b0;
      bias        = 1'b0;
      gene1_in    = '0;
      gene2_in    = '0;
      genome_last = 1'b0;
      out_ready   = 1'b1;
      rand_done   = 1'b0;
      m_lfsr      = 16'h0001;
      m_count     = 0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Reset values, FSM idle in SEED
      @(negedge clk);
      check("rst_in_ready", {63'b0, in_ready}, 64'd0);
      check("rst_out_valid", {63'b0, out_valid}, 64'd0);
      check("rst_child", child_gene, 64'd0);
      check("rst_count", {54'b0, gene_count}, 64'd0);
      check("rst_done", {63'b0, genome_done}, 64'd0);
      @(posedge clk); #1;

      // Test 1: zero seed maps to 1, byte0 from gene2
      load_seed(16'h0000);
      @(negedge clk);
      check("run_in_ready", {63'b0, in_ready}, 64'd1);
      check("pre_out_valid", {63'b0, out_valid}, 64'd0);
      @(posedge clk); #1;
      send_pair(1'b0, 1'b0, 64'h1111111111111111, 64'h2222222222222222, 1'b0);
      check("t1_latency", {63'b0, out_valid}, 64'd1);
      check("t1_child", child_gene, 64'h1111111111111122);

      // Test 2: bias pair passes gene1 and leaves the LFSR alone
      send_pair(1'b0, 1'b1, 64'hDEADBEEF00000001, 64'h0123456789ABCDEF, 1'b0);
      check("t2_bias_child", child_gene, 64'hDEADBEEF00000001);
      send_pair(1'b0, 1'b0, 64'hAAAAAAAAAAAAAAAA, 64'h5555555555555555, 1'b1);
      wait_done(3);

      // Test 3: bubbles interleaved, last on the final bubble
      for (int i = 0; i < 7; i++)
         send_pair((i % 2) == 0, 1'b0, {$urandom, $urandom}, {$urandom, $urandom}, i == 6);
      wait_done(3);

      // Test 4: backpressure holds the head and stalls intake after two
      out_ready = 1'b0;
      send_pair(1'b0, 1'b0, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0);
      send_pair(1'b0, 1'b0, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("t4_ready_full", {63'b0, in_ready}, 64'd0);
         check("t4_valid_hold", {63'b0, out_valid}, 64'd1);
         check("t4_child_hold", child_gene, exp_q[0]);
      end
      @(posedge clk); #1;
      fork
         send_pair(1'b0, 1'b0, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0);
         begin
            repeat (2) @(negedge clk);
            @(posedge clk); #1;
            out_ready = 1'b1;
         end
      join
      send_pair(1'b0, 1'b0, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1);
      wait_done(4);

      // Reseed while in RUN, then a random genome under random backpressure
      load_seed(16'($urandom));
      fork
         begin
            for (int i = 0; i < 24; i++)
               send_pair($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
                         {$urandom, $urandom}, {$urandom, $urandom}, i == 23);
            rand_done = 1'b1;
         end
         begin
            while (!rand_done) begin
               @(posedge clk); #1;
               out_ready = ($urandom_range(0, 3) != 0);
            end
            out_ready = 1'b1;
         end
      join
      wait_done(m_count);

      // Test 6: weight at +127 with delta +3 stays at +127
      s6 = 16'h0001;
      for (int s = 1; s < 256; s++) begin
         tmp = lfsr_step(16'(s));
         if (tmp[2:0] == 3'd3) begin
            s6 = 16'(s);
            break;
         end
      end
      load_seed(s6);
      g1 = {$urandom, $urandom};
      g2 = {$urandom, $urandom};
      g1[7:0] = 8'h7F;
      g2[7:0] = 8'h7F;
      send_pair(1'b0, 1'b0, g1, g2, 1'b1);
      check("t6_weight_sat", {56'b0, child_gene[7:0]}, 64'h7F);
      wait_done(1);

      // Test 5: reset while draining two buffered children
      out_ready = 1'b0;
      send_pair(1'b0, 1'b0, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0);
      send_pair(1'b0, 1'b0, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1);
      @(negedge clk);
      check("t5_drain_ready", {63'b0, in_ready}, 64'd0);
      check("t5_drain_valid", {63'b0, out_valid}, 64'd1);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      exp_q.delete();
      m_count = 0;
      @(negedge clk);
      check("t5_valid", {63'b0, out_valid}, 64'd0);
      check("t5_count", {54'b0, gene_count}, 64'd0);
      check("t5_ready", {63'b0, in_ready}, 64'd0);
      check("t5_done", {63'b0, genome_done}, 64'd0);
      repeat (3) @(negedge clk);
      check("t5_ready_hold", {63'b0, in_ready}, 64'd0);
      @(posedge clk); #1;
      out_ready = 1'b1;
      load_seed(16'($urandom));
      @(negedge clk);
      check("t5_ready_seeded", {63'b0, in_ready}, 64'd1);
      @(posedge clk); #1;
      send_pair(1'b0, 1'b0, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0);
      send_pair(1'b0, 1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1);
      wait_done(2);

      repeat (4) @(negedge clk);
      check("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
      $finish;
   end

endmodule

// File: doc/pe_crossover_stage.md
Name: pe_crossover_stage

Overview:
- Downstream of pe_front_end in the NEAT PE; consumes its aligned parent gene pairs (gene1/gene2 with bubble and bias flags) and produces one child gene per non-bubble pair.
- Child is formed by per-attribute uniform crossover driven by an internal 16-bit LFSR.
- Output goes through a 2-entry buffer with a valid/ready handshake toward the genome writer.
- Tracks the gene count per genome and pulses a done flag at each genome end.

Parameters:
- GENE_SZ, 64, gene width in bits; must be a multiple of ATTR_SZ.
- ATTR_SZ, 8, attribute width; gene holds NATTR = GENE_SZ/ATTR_SZ attributes, attr i = bits [i*ATTR_SZ +: ATTR_SZ]; attr 0 = signed weight.
- CNT_SZ, 10, width of the per-genome gene counter.
- MUT_RATE, 8'd16, mutation threshold; used only with MUTATE_EN.

Ports:
- clk  in  1  clock, all logic rising-edge.
- rst  in  1  synchronous reset, active-high.
- seed_load  in  1  loads seed into the LFSR.
- seed  in  16  LFSR seed value.
- in_valid  in  1  input pair valid.
- in_ready  out  1  stage can accept a pair.
- bubble  in  1  pair carries no gene.
- bias  in  1  pair is the bias gene.
- gene1_in  in  GENE_SZ  parent-1 gene (fitter parent).
- gene2_in  in  GENE_SZ  parent-2 gene.
- genome_last  in  1  this pair is the last of the genome.
- out_valid  out  1  child_gene valid.
- out_ready  in  1  consumer accepts child.
- child_gene  out  GENE_SZ  head of the output buffer.
- gene_count  out  CNT_SZ  children emitted for the current genome.
- genome_done  out  1  one-cycle pulse at genome end.

Behaviour:
- Reset values: in_ready=0, out_valid=0, child_gene=0, gene_count=0, genome_done=0.
  - State resets to SEED, buffer resets empty, LFSR resets to 16'h0001.
- Accept: a pair is accepted when in_valid & in_ready on a clock edge.

FSM:
- SEED:
  - in_ready=0.
  - On seed_load, LFSR <= seed, or 16'h0001 if seed==0; go to RUN.
- RUN:
  - in_ready = (buffer occupancy < 2).
  - Accepting with genome_last=1 moves to DRAIN.
  - seed_load in RUN reloads the LFSR and stays in RUN.
- DRAIN:
  - in_ready=0; waits until the buffer is empty.
  - Then genome_done=1 for exactly one cycle, showing the final gene_count on that cycle.
  - Next cycle gene_count <= 0 and the FSM returns to RUN.

Crossover:
- bubble=1: no child, LFSR does not advance, genome_last is still honoured.
- bias=1 (and bubble=0): child = gene1_in unchanged; LFSR does not advance.
- Otherwise, for each attr i, child attr i = lfsr[i % 16] ? gene2 attr i : gene1 attr i, using the LFSR value before the advance.
- The LFSR then advances one step: Galois, taps 16'hB400, lfsr <= (lfsr>>1) ^ (lfsr[0] ? 16'hB400 : 0).
- bubble and bias both high: bubble wins.

Output buffer:
- Latency: a child accepted at edge N is visible with out_valid=1 after edge N.
- Output pops when out_valid & out_ready.
- gene_count increments on each push and saturates at all-ones.
- Simultaneous push and pop with a full buffer: not possible, since in_ready=0 when full.
- Simultaneous push and pop otherwise: occupancy unchanged, FIFO order kept.
- out_ready low: child_gene and out_valid hold stable.
- Reset mid-genome: buffer contents are discarded, all state returns to SEED, and the LFSR must be reseeded.

Optional Feature:
- Macro: PE_CROSSOVER_MUTATE_EN.
- When defined, the weight (attr 0) of every crossed-over child (not bias, not bubble) is perturbed:
  - Condition: if the post-advance lfsr[15:8] < MUT_RATE, add the signed 3-bit delta lfsr[2:0] (range -4..+3) to the weight.
  - The add is signed and saturates to the ATTR_SZ limits: 127 / -128 for ATTR_SZ=8.
- When not defined: no mutation logic; the child is pure crossover and MUT_RATE is unused.

Test Plan:
1. Reset, seed=0 load -> LFSR=16'h0001, FSM in RUN.
   - Pair gene1=64'h1111..11, gene2=64'h2222..22 -> child byte0 from gene2 (lfsr[0]=1), bytes 1..7 from gene1; out_valid one cycle after accept.
2. bias=1, gene1=64'hDEADBEEF_00000001 -> child identical to gene1.
   - Next non-bias pair uses the same LFSR value as if the bias pair were absent.
3. Bubble pairs interleaved with 3 real pairs, last on the final bubble -> 3 children emitted.
   - genome_done pulses once with gene_count=3, then gene_count reads 0.
4. out_ready=0 while streaming 3 pairs -> in_ready drops after 2 accepts.
   - child_gene holds stable; releasing out_ready drains in order.
5. Assert rst during DRAIN with 2 buffered -> out_valid=0, gene_count=0, in_ready=0 until seed_load.
6. With PE_CROSSOVER_MUTATE_EN and MUT_RATE=8'hFF, weight 8'h7F and delta +3 -> weight saturates at 8'h7F.
   - Same test without the macro -> weight passes unchanged.
